// File: rtl/md_unit.sv
// md_unit: radix-2 iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Define MD_EARLY_OUT_EN to let multiplies exit once the remaining multiplier magnitude is zero.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mc, acc_n;
  logic [WIDTH-1:0] mb, ma_n, mb_n;
  logic [WIDTH:0] r, rs;
  logic mul, neg_h, neg_l, sa, sb, ge, last, early;
  always_comb begin
    sa = ~op[0] & SrcA[WIDTH-1];
    sb = ~op[0] & SrcB[WIDTH-1];
    ma_n = sa ? -SrcA : SrcA;
    mb_n = sb ? -SrcB : SrcB;
    r = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rs = r - {1'b0, mc[WIDTH-1:0]};
    ge = r >= {1'b0, mc[WIDTH-1:0]};
    // divide: restoring step on {remainder, dividend/quotient}; multiply: add shifted multiplicand
    acc_n = mul ? acc + (mb[0] ? mc : '0)
                : {ge ? rs[WIDTH-1:0] : r[WIDTH-1:0], acc[WIDTH-2:0], ge};
    last = cnt == CNT_W'(WIDTH - 1) || early;
  end
`ifdef MD_EARLY_OUT_EN
  assign early = mul && mb[WIDTH-1:1] == '0;
`else
  assign early = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      cnt   <= '0;
      acc   <= '0;
      mc    <= '0;
      mb    <= '0;
      mul   <= 1'b0;
      neg_h <= 1'b0;
      neg_l <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && hi_we) HI <= wdata;
      if (state == IDLE && lo_we) LO <= wdata;
      case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          cnt   <= '0;
          mul   <= ~op[1];
          mb    <= mb_n;
          mc    <= {{WIDTH{1'b0}}, op[1] ? mb_n : ma_n};
          if (op[1] && SrcB == '0) begin
            state <= FIN;
            acc   <= {SrcA, {WIDTH{1'b1}}};
            neg_h <= 1'b0;
            neg_l <= 1'b0;
          end else begin
            state <= ITER;
            acc   <= op[1] ? {{WIDTH{1'b0}}, ma_n} : '0;
            neg_h <= sa;
            neg_l <= sa ^ sb;
          end
        end
        ITER: begin
          acc   <= acc_n;
          mc    <= mul ? mc << 1 : mc;
          mb    <= mb >> 1;
          cnt   <= cnt + 1'b1;
          state <= last ? FIN : ITER;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (mul) {HI, LO} <= neg_l ? -acc : acc;
          else begin
            HI <= neg_h ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            LO <= neg_l ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against an arithmetic reference model.
module tb_md_unit;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [W-1:0] SrcA = 0, SrcB = 0, wdata = 0;
  logic busy, done;
  logic [W-1:0] HI, LO;
  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {logic [W-1:0] hi; logic [W-1:0] lo; int at;} exp_t;
  exp_t sb_q[$];

  md_unit dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
               .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
               .HI(HI), .LO(LO));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, int e);
    exp_t x;
    longint va, vb, qq, rr;
    logic [63:0] p;
    logic [W-1:0] mag;
    int it;
    va = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    vb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    it = W;
    if (o[1] && b == 0) begin
      x.hi = a; x.lo = '1; x.at = e + 1;
      return x;
    end
    if (!o[1]) begin
      p = va * vb;
      {x.hi, x.lo} = p;
`ifdef MD_EARLY_OUT_EN
      mag = (!o[0] && b[W-1]) ? -b : b;
      it = 1;
      for (int i = 0; i < W; i++) if (mag[i]) it = i + 1;
`endif
    end else begin
      qq = va / vb;
      rr = va % vb;
      x.lo = qq[W-1:0];
      x.hi = rr[W-1:0];
    end
    x.at = e + it + 1;
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && done) begin
      chk("busy_low_at_done", {63'b0, busy}, 64'd0);
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        x = sb_q.pop_front();
        chk("result_hi", {32'b0, HI}, {32'b0, x.hi});
        chk("result_lo", {32'b0, LO}, {32'b0, x.lo});
        chk("done_cycle", 64'(cyc), 64'(x.at));
      end
    end
  end

  task automatic issue(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    @(negedge clk);
    op = o; SrcA = a; SrcB = b; start = 1;
    sb_q.push_back(model(o, a, b, cyc + 1));
    @(posedge clk);
    #1 start = 0; hi_we = 0; lo_we = 0;
    SrcA = $urandom; SrcB = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done after 60 cycles expected %0d pending results", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic mt(logic h, logic [W-1:0] d);
    @(negedge clk);
    hi_we = h; lo_we = !h; wdata = d;
    @(posedge clk);
    #1 hi_we = 0; lo_we = 0;
  endtask

  initial begin
    logic [1:0] o;
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'b0, HI}, 64'd0);
    chk("reset_lo", {32'b0, LO}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    rst_n = 1;

    issue(2'b01, 32'hF0F0FFFF, 32'h0000F0F0);
    @(negedge clk);
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    wait_done();
    chk("multu_vec_hi", {32'b0, HI}, 64'h0000E2C3);
    chk("multu_vec_lo", {32'b0, LO}, 64'hD1EF0F10);

    issue(2'b00, 32'hFFFFFFFF, 32'h00000002); wait_done();
    chk("mult_neg_hi", {32'b0, HI}, 64'hFFFFFFFF);
    chk("mult_neg_lo", {32'b0, LO}, 64'hFFFFFFFE);

    issue(2'b10, 32'hFFFFFFF9, 32'h00000002); wait_done();
    chk("div_neg_lo", {32'b0, LO}, 64'hFFFFFFFD);
    chk("div_neg_hi", {32'b0, HI}, 64'hFFFFFFFF);

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF); wait_done();
    chk("div_ovf_lo", {32'b0, LO}, 64'h80000000);
    chk("div_ovf_hi", {32'b0, HI}, 64'h0);

    issue(2'b11, 32'h00000FFF, 32'h0); wait_done();
    chk("div0_hi", {32'b0, HI}, 64'h00000FFF);
    chk("div0_lo", {32'b0, LO}, 64'hFFFFFFFF);

    issue(2'b01, 32'd3, 32'd1); wait_done();
    chk("early_lo", {32'b0, LO}, 64'd3);
    chk("early_hi", {32'b0, HI}, 64'd0);

    mt(1, 32'h13572468);
    mt(0, 32'h2468ACE0);
    @(negedge clk);
    chk("mthi", {32'b0, HI}, 64'h13572468);
    chk("mtlo", {32'b0, LO}, 64'h2468ACE0);

    @(negedge clk);
    hi_we = 1; wdata = 32'h00001234;
    issue(2'b01, 32'd7, 32'd9);
    @(negedge clk);
    chk("mthi_same_edge", {32'b0, HI}, 64'h00001234);
    wait_done();

    mt(1, 32'hA5A5A5A5);
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
    repeat (4) @(negedge clk);
    start = 1; op = 2'b10; SrcA = 32'h55; SrcB = 32'h3; hi_we = 1; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 0; hi_we = 0;
    @(negedge clk);
    chk("busy_ignores_mthi", {32'b0, HI}, 64'hA5A5A5A5);
    chk("busy_during_repulse", {63'b0, busy}, 64'd1);
    wait_done();

    issue(2'b01, 32'hCAFEF00D, 32'h87654321);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    sb_q.delete();
    #1;
    chk("abort_hi", {32'b0, HI}, 64'd0);
    chk("abort_lo", {32'b0, LO}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("abort_idle", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = 32'($urandom_range(0, 255));
        2: b = -32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      issue(o, a, b);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
